// File: rtl/arm_pkg.sv
// Shared definitions for the operand forwarding controller.
// Holds register-file geometry, forwarding-mux select encodings and the
// stall FSM state type used by operand_fwd_ctrl and load_scoreboard.
package arm_pkg;

    localparam int unsigned REG_AW   = 4;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned PEND_W   = 2;
    localparam int unsigned CNT_W    = 16;

    // R15 reads as the PC, never as a forwarded value
    localparam logic [REG_AW-1:0] PC_REG = REG_AW'(15);

    localparam logic [SEL_W-1:0] A_SEL_REG  = 2'b00;
    localparam logic [SEL_W-1:0] A_SEL_ALU  = 2'b01;
    localparam logic [SEL_W-1:0] A_SEL_PC   = 2'b11;

    localparam logic [SEL_W-1:0] B_SEL_REG  = 2'b00;
    localparam logic [SEL_W-1:0] B_SEL_ALU  = 2'b01;
    localparam logic [SEL_W-1:0] B_SEL_VALB = 2'b11;

    localparam logic [SEL_W-1:0] S_SEL_REG  = 2'b00;
    localparam logic [SEL_W-1:0] S_SEL_ALU  = 2'b01;
    localparam logic [SEL_W-1:0] S_SEL_ZERO = 2'b11;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } fwd_state_t;

endpackage

// File: rtl/load_scoreboard.sv
// Per-register load latency scoreboard.
// A load leaving execute arms its destination counter with LOAD_LAT; every
// other nonzero counter counts down once per cycle. busy[i] is set while
// register i still awaits load data.
// Ports: clk, rst (async, active high), set_en/set_addr (arm a counter),
//        busy (one bit per register, combinational from the counters).
module load_scoreboard
    import arm_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [REG_AW-1:0]   set_addr,
    output logic [NUM_REGS-1:0] busy
);

    logic [PEND_W-1:0] pend [NUM_REGS];

    // Arm on load (re-arming overrides any count in flight), else count down
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                pend[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (set_en && (set_addr == REG_AW'(i))) begin
                    pend[i] <= PEND_W'(LOAD_LAT);
                end else if (pend[i] != '0) begin
                    pend[i] <= pend[i] - PEND_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            busy[i] = (pend[i] != '0);
        end
    end

endmodule

// File: rtl/operand_fwd_ctrl.sv
// Operand forwarding and load-use interlock for the decode stage.
// Picks forwarding-mux selects for the A, B and shift operands, detects
// load-use hazards against the execute stage and the load scoreboard, and
// drives stall / bubble / operand enables plus a saturating stall counter.
// Ports: clk, rst (async, active high); dec_* decode-stage sources;
//        ex_* execute-stage destination; flush kills decode;
//        sel_*_in forwarding selects; en_A/B/S operand enables;
//        stall, ex_bubble, stall_count.
module operand_fwd_ctrl
    import arm_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_A_addr,
    input  logic [REG_AW-1:0] dec_B_addr,
    input  logic [REG_AW-1:0] dec_S_addr,
    input  logic              dec_A_use,
    input  logic              dec_B_use,
    input  logic              dec_S_use,
    input  logic              dec_B_imme,
    input  logic              ex_valid,
    input  logic              ex_wen,
    input  logic [REG_AW-1:0] ex_waddr,
    input  logic              ex_is_load,
    input  logic              flush,
    output logic [SEL_W-1:0]  sel_A_in,
    output logic [SEL_W-1:0]  sel_B_in,
    output logic [SEL_W-1:0]  sel_shift_in,
    output logic              en_A,
    output logic              en_B,
    output logic              en_S,
    output logic              stall,
    output logic              ex_bubble,
    output logic [CNT_W-1:0]  stall_count
);

    fwd_state_t          state;
    logic [NUM_REGS-1:0] busy;
    logic                ex_alu_wr;
    logic                ex_ld_wr;
    logic                use_a;
    logic                use_b;
    logic                hz_a;
    logic                hz_b;
    logic                hz_s;
    logic                hazard;

    assign ex_alu_wr = ex_valid & ex_wen & ~ex_is_load;
    assign ex_ld_wr  = ex_valid & ex_wen &  ex_is_load;

    // PC reads and immediate B operands never wait on a load
    assign use_a = dec_A_use & (dec_A_addr != PC_REG);
    assign use_b = dec_B_use & ~dec_B_imme;

    // A source waits if its load is still in flight or is in execute now
    assign hz_a = use_a & (busy[dec_A_addr] | (ex_ld_wr & (ex_waddr == dec_A_addr)));
    assign hz_b = use_b & (busy[dec_B_addr] | (ex_ld_wr & (ex_waddr == dec_B_addr)));
    assign hz_s = dec_S_use & (busy[dec_S_addr] | (ex_ld_wr & (ex_waddr == dec_S_addr)));

    assign hazard = dec_valid & ~flush & (hz_a | hz_b | hz_s);

    load_scoreboard #(
        .LOAD_LAT (LOAD_LAT)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (ex_ld_wr),
        .set_addr (ex_waddr),
        .busy     (busy)
    );

    // Selects and interlock outputs; everything is held at zero during reset
    always_comb begin
        sel_A_in     = A_SEL_REG;
        sel_B_in     = B_SEL_REG;
        sel_shift_in = S_SEL_REG;
        en_A         = 1'b0;
        en_B         = 1'b0;
        en_S         = 1'b0;
        stall        = 1'b0;
        ex_bubble    = 1'b0;
        if (!rst) begin
            if (dec_valid) begin
                if (dec_A_addr == PC_REG) begin
                    sel_A_in = A_SEL_PC;
                end else if (ex_alu_wr && (ex_waddr == dec_A_addr)) begin
                    sel_A_in = A_SEL_ALU;
                end

                if (dec_B_imme) begin
                    sel_B_in = B_SEL_VALB;
                end else if (ex_alu_wr && (ex_waddr == dec_B_addr)) begin
                    sel_B_in = B_SEL_ALU;
                end

                if (!dec_S_use) begin
                    sel_shift_in = S_SEL_ZERO;
                end else if (ex_alu_wr && (ex_waddr == dec_S_addr)) begin
                    sel_shift_in = S_SEL_ALU;
                end
            end
            stall     = hazard;
            ex_bubble = hazard | flush;
            en_A      = dec_valid & ~flush & ~hazard;
            en_B      = dec_valid & ~flush & ~hazard;
            en_S      = dec_valid & ~flush & ~hazard;
        end
    end

    // Stall FSM tracks the combinational hazard; stall cycles are counted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            stall_count <= '0;
        end else begin
            case (state)
                RUN:   if (hazard)  state <= STALL;
                STALL: if (!hazard) state <= RUN;
            endcase
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Directed self-checking bench for operand_fwd_ctrl (LOAD_LAT = 2).
module tb_operand_fwd_ctrl;

    logic        clk;
    logic        rst;
    logic        dec_valid;
    logic [3:0]  dec_A_addr, dec_B_addr, dec_S_addr;
    logic        dec_A_use, dec_B_use, dec_S_use, dec_B_imme;
    logic        ex_valid, ex_wen, ex_is_load;
    logic [3:0]  ex_waddr;
    logic        flush;
    logic [1:0]  sel_A_in, sel_B_in, sel_shift_in;
    logic        en_A, en_B, en_S, stall, ex_bubble;
    logic [15:0] stall_count;

    int n_pass  = 0;
    int n_total = 0;

    operand_fwd_ctrl #(.LOAD_LAT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (dec_valid),
        .dec_A_addr   (dec_A_addr),
        .dec_B_addr   (dec_B_addr),
        .dec_S_addr   (dec_S_addr),
        .dec_A_use    (dec_A_use),
        .dec_B_use    (dec_B_use),
        .dec_S_use    (dec_S_use),
        .dec_B_imme   (dec_B_imme),
        .ex_valid     (ex_valid),
        .ex_wen       (ex_wen),
        .ex_waddr     (ex_waddr),
        .ex_is_load   (ex_is_load),
        .flush        (flush),
        .sel_A_in     (sel_A_in),
        .sel_B_in     (sel_B_in),
        .sel_shift_in (sel_shift_in),
        .en_A         (en_A),
        .en_B         (en_B),
        .en_S         (en_S),
        .stall        (stall),
        .ex_bubble    (ex_bubble),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dec_valid = 0; dec_A_addr = 0; dec_B_addr = 0; dec_S_addr = 0;
        dec_A_use = 0; dec_B_use = 0; dec_S_use = 0; dec_B_imme = 0;
        ex_valid = 0; ex_wen = 0; ex_waddr = 0; ex_is_load = 0; flush = 0;
    endtask

    task automatic set_ex(input logic v, input logic ld, input logic [3:0] wa);
        ex_valid = v; ex_wen = v; ex_is_load = ld; ex_waddr = wa;
    endtask

    initial begin
        // Reset with busy-looking inputs: everything must read zero
        idle_inputs();
        rst = 1;
        dec_valid = 1; dec_A_addr = 15; dec_A_use = 1; dec_B_imme = 1;
        set_ex(1, 1, 4'd15);
        #3;
        check("rst_sel_A", 16'(sel_A_in), 16'h0);
        check("rst_sel_B", 16'(sel_B_in), 16'h0);
        check("rst_sel_S", 16'(sel_shift_in), 16'h0);
        check("rst_stall", 16'(stall), 16'h0);
        check("rst_bubble", 16'(ex_bubble), 16'h0);
        check("rst_en_A", 16'(en_A), 16'h0);
        check("rst_count", stall_count, 16'h0);
        tick();
        rst = 0;
        idle_inputs();

        // ALU forward of R3 to A and B, shift unused
        set_ex(1, 0, 4'd3);
        dec_valid = 1; dec_A_addr = 3; dec_B_addr = 3; dec_A_use = 1; dec_B_use = 1;
        #1;
        check("alu_sel_A", 16'(sel_A_in), 16'h1);
        check("alu_sel_B", 16'(sel_B_in), 16'h1);
        check("alu_sel_S", 16'(sel_shift_in), 16'h3);
        check("alu_stall", 16'(stall), 16'h0);
        check("alu_en_A", 16'(en_A), 16'h1);
        check("alu_bubble", 16'(ex_bubble), 16'h0);
        tick();

        // R15 on A reads PC; R15 on B forwards from ALU
        set_ex(1, 0, 4'd15);
        dec_A_addr = 15; dec_B_addr = 15;
        #1;
        check("pc_sel_A", 16'(sel_A_in), 16'h3);
        check("pc_sel_B", 16'(sel_B_in), 16'h1);
        check("pc_stall", 16'(stall), 16'h0);
        tick();

        // No valid decode: selects 00, enables off
        set_ex(1, 0, 4'd3);
        dec_valid = 0; dec_A_addr = 3; dec_B_addr = 3;
        #1;
        check("inv_sel_A", 16'(sel_A_in), 16'h0);
        check("inv_sel_B", 16'(sel_B_in), 16'h0);
        check("inv_sel_S", 16'(sel_shift_in), 16'h0);
        check("inv_en_B", 16'(en_B), 16'h0);
        check("inv_stall", 16'(stall), 16'h0);

        // Shift operand forwarding and non-matching register
        set_ex(1, 0, 4'd7);
        dec_valid = 1; dec_A_use = 0; dec_B_use = 0; dec_A_addr = 0; dec_B_addr = 0;
        dec_S_use = 1; dec_S_addr = 7;
        #1;
        check("sh_sel_alu", 16'(sel_shift_in), 16'h1);
        dec_S_addr = 8;
        #1;
        check("sh_sel_reg", 16'(sel_shift_in), 16'h0);
        check("sh_en_S", 16'(en_S), 16'h1);
        tick();

        // Load-use on R5: three stall cycles, then proceed
        idle_inputs();
        set_ex(1, 1, 4'd5);
        dec_valid = 1; dec_A_addr = 5; dec_A_use = 1;
        #1;
        check("ld0_stall", 16'(stall), 16'h1);
        check("ld0_bubble", 16'(ex_bubble), 16'h1);
        check("ld0_en_A", 16'(en_A), 16'h0);
        check("ld0_sel_A", 16'(sel_A_in), 16'h0);
        tick();
        set_ex(0, 0, 4'd0);
        #1;
        check("ld1_stall", 16'(stall), 16'h1);
        check("ld1_count", stall_count, 16'd1);
        tick();
        #1;
        check("ld2_stall", 16'(stall), 16'h1);
        check("ld2_count", stall_count, 16'd2);
        tick();
        #1;
        check("ld3_stall", 16'(stall), 16'h0);
        check("ld3_sel_A", 16'(sel_A_in), 16'h0);
        check("ld3_en_A", 16'(en_A), 16'h1);
        check("ld3_count", stall_count, 16'd3);
        tick();

        // Immediate B overrides a load match on B_addr
        idle_inputs();
        set_ex(1, 1, 4'd9);
        dec_valid = 1; dec_B_addr = 9; dec_B_use = 1; dec_B_imme = 1;
        #1;
        check("imm_sel_B", 16'(sel_B_in), 16'h3);
        check("imm_stall", 16'(stall), 16'h0);
        check("imm_en_B", 16'(en_B), 16'h1);
        tick();

        // R9 now pending: flush hides the hazard but keeps the counter
        idle_inputs();
        dec_valid = 1; dec_A_addr = 9; dec_A_use = 1; flush = 1;
        #1;
        check("fl_stall", 16'(stall), 16'h0);
        check("fl_bubble", 16'(ex_bubble), 16'h1);
        check("fl_en_A", 16'(en_A), 16'h0);
        check("fl_en_S", 16'(en_S), 16'h0);
        tick();
        flush = 0;
        #1;
        check("fl_next_stall", 16'(stall), 16'h1);
        check("fl_next_count", stall_count, 16'd3);
        tick();
        #1;
        check("fl_done_stall", 16'(stall), 16'h0);
        check("fl_done_count", stall_count, 16'd4);
        tick();

        // Reset in the middle of a load stall on R6
        idle_inputs();
        set_ex(1, 1, 4'd6);
        dec_valid = 1; dec_A_addr = 6; dec_A_use = 1;
        #1;
        check("rs_stall0", 16'(stall), 16'h1);
        tick();
        set_ex(0, 0, 4'd0);
        #1;
        check("rs_stall1", 16'(stall), 16'h1);
        check("rs_count1", stall_count, 16'd5);
        rst = 1;
        #1;
        check("rs_now_stall", 16'(stall), 16'h0);
        check("rs_now_sel_A", 16'(sel_A_in), 16'h0);
        check("rs_now_count", stall_count, 16'h0);
        check("rs_now_en_A", 16'(en_A), 16'h0);
        tick();
        rst = 0;
        #1;
        check("rs_after_stall", 16'(stall), 16'h0);
        check("rs_after_en_A", 16'(en_A), 16'h1);
        tick();
        #1;
        check("rs_after_count", stall_count, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/operand_fwd_ctrl.md
OPERAND_FWD_CTRL -- requirements
Module: operand_fwd_ctrl

Interface
REQ-001 The block SHALL have parameter LOAD_LAT, default 2, meaning the cycles from a load leaving execute until its data is readable from the regfile (legal range 1..3).
REQ-002 The block SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- dec_valid  in  1  decode stage holds a valid instruction.
- dec_A_addr / dec_B_addr / dec_S_addr  in  4 each  source registers for A, B and shift amount.
- dec_A_use / dec_B_use / dec_S_use  in  1 each  corresponding source is read.
- dec_B_imme  in  1  B operand comes from the immediate/shifted value, not a register.
- ex_valid, ex_wen  in  1 each  execute stage valid; execute stage writes a register.
- ex_waddr  in  4  execute destination register.
- ex_is_load  in  1  execute instruction is a load (data returns via the RAM write path).
- flush  in  1  kill the decode instruction (taken branch).
- sel_A_in, sel_B_in, sel_shift_in  out  2 each  datapath forwarding-mux selects.
- en_A, en_B, en_S  out  1 each  operand register enables.
- stall  out  1  hold fetch/decode.
- ex_bubble  out  1  inject a NOP into execute next cycle.
- stall_count  out  16  saturating count of stall cycles.

Function
REQ-003 Select encodings SHALL be: A 00 regfile, 01 ALU_out, 11 PC; B 00 regfile, 01 ALU_out, 11 val_B; shift 00 regfile, 01 ALU_out, 11 zero.
REQ-004 For A, address 15 SHALL select 11; else an execute-stage non-load write match (ex_valid & ex_wen & !ex_is_load & ex_waddr==dec_A_addr) SHALL select 01; else 00.
REQ-005 For B, dec_B_imme SHALL select 11 and take priority over ALU forwarding; otherwise the same match rule as A SHALL apply.
REQ-006 For shift, dec_S_use=0 SHALL select 11; otherwise the same match rule SHALL apply.
REQ-007 Select outputs SHALL be combinational from the current inputs, with no added latency.
REQ-008 The block SHALL keep a 2-bit pending counter per register, pend[0..15].
- ex_valid & ex_wen & ex_is_load SHALL load pend[ex_waddr] with LOAD_LAT on the clock edge, even if that counter is already nonzero.
- Every other nonzero counter SHALL decrement by 1 per cycle.
- Non-load writes SHALL NOT modify any counter.
REQ-009 A hazard SHALL exist when dec_valid & !flush and either:
- a used source (A with address ≠15, B with !dec_B_imme, S) has pend ≠ 0; or
- the source matches an execute-stage load destination.
REQ-010 The FSM SHALL have states RUN and STALL.
- RUN→STALL when a hazard exists.
- STALL→RUN in the first cycle the hazard is absent.
- Hazard evaluation SHALL be combinational each cycle, and the state SHALL only mirror it.
REQ-011 While a hazard exists, stall=1, ex_bubble=1 and en_A=en_B=en_S=0; otherwise en_A=en_B=en_S=dec_valid & !flush and stall=ex_bubble=0.
REQ-012 flush=1 SHALL suppress a hazard, force ex_bubble=1 and the enables to 0, and leave the pending counters unchanged.
REQ-013 stall_count SHALL increment on each clock edge where stall=1 and saturate at 0xFFFF.
REQ-014 dec_valid=0 SHALL produce select 00 on every operand, no stall, and enables of 0.

Reset
REQ-015 rst=1 SHALL immediately clear all pend counters, set the state to RUN and set stall_count to 0.
REQ-016 While rst=1, every output SHALL be 0 and every select SHALL be 00, regardless of other inputs.
REQ-017 Reset asserted mid-stall SHALL abort the stall; the first instruction presented after reset SHALL be treated as hazard-free unless the current execute stage matches it.

Structure
REQ-018 The select encodings (A_SEL_REG/ALU/PC, B_SEL_REG/ALU/VALB, S_SEL_REG/ALU/ZERO) and the state enum SHALL live in the shared package arm_pkg.
REQ-019 The scoreboard SHALL be a single sub-module load_scoreboard (16×2-bit counters, one set port, a 16-bit busy vector out); all other logic SHALL be in operand_fwd_ctrl.

Verification
REQ-020 Execute ALU write to R3 with decode A=R3, B=R3, S unused → sel_A_in=01, sel_B_in=01, sel_shift_in=11, stall=0.
REQ-021 Load to R5 in execute, decode A=R5, LOAD_LAT=2 → stall=1 for 3 consecutive cycles (execute match, then pend 2, then pend 1), then sel_A_in=00, en_A=1, and stall_count=3.
REQ-022 Decode A=R15 while execute writes R15 via the ALU → sel_A_in=11, no stall.
REQ-023 Decode dec_B_imme=1 with B_addr matching an execute load → sel_B_in=11, no stall.
REQ-024 Hazard present with flush=1 → stall=0, ex_bubble=1, en_*=0, and pend unchanged on the next cycle.
REQ-025 rst pulsed during a load stall → immediately stall=0, selects 00 and stall_count=0; after release, decode of the old load register does not stall.
